// File: rtl/dmem_store_responder.sv
// dmem_store_responder
//   Data-memory responder for the pipelined MIPS store/load port. Stores
//   (sb/sh/sw) are queued in a small in-order store buffer. The buffer
//   retires one entry per cycle into a single-port word array. Retirement
//   happens only in cycles with no core memory traffic, or while the core
//   is stalled. Word loads read the array combinationally. A load whose
//   word is still sitting in the buffer stalls the core until every
//   matching entry has retired.
//
// Parameters
//   MEM_WORDS  number of 32-bit words in the array (word index taken from
//              dataadr[log2(MEM_WORDS)+1:2], upper address bits ignored)
//   SB_DEPTH   store-buffer entries, power of two, >= 2
//
// Ports
//   clk           system clock, all state updates on posedge
//   reset         synchronous, active-high; empties the store buffer and
//                 clears misalign_err (array contents are kept)
//   memwrite[1:0] 00 none, 01 byte, 10 half, 11 word store
//   memread       word-load request
//   dataadr[31:0] byte address of the load/store
//   writedata     right-aligned store data
//   readdata      combinational load result (0 unless a load completes)
//   stall         core holds all request inputs while high
//   misalign_err  sticky flag, set by a dropped misaligned store
//
// Optional build macro
//   DMEM_STORE_TRACE_EN  adds a retired-store counter and $display trace of
//                        every retired and every dropped misaligned store.
//                        Ports and cycle behaviour do not change.

module dmem_store_responder #(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned SB_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memwrite,
  input  logic        memread,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misalign_err
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(SB_DEPTH);

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_BYTE = 2'b01,
    ST_HALF = 2'b10,
    ST_WORD = 2'b11
  } st_kind_e;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  st_kind_e          kind;
  logic [IDX_W-1:0]  req_idx;
  logic              store_req;
  logic              aligned;
  logic [31:0]       st_data;
  logic [3:0]        st_mask;
  logic              unused_adr_bits;

  assign kind            = st_kind_e'(memwrite);
  assign req_idx         = dataadr[IDX_W+1:2];
  assign store_req       = (kind != ST_NONE);
  assign unused_adr_bits = ^dataadr[31:IDX_W+2];

  // Sub-word data is replicated across lanes so the mask alone picks the
  // destination bytes.
  always_comb begin
    aligned = 1'b1;
    st_data = '0;
    st_mask = '0;
    case (kind)
      ST_BYTE: begin
        st_data = {4{writedata[7:0]}};
        st_mask = 4'b0001 << dataadr[1:0];
      end
      ST_HALF: begin
        aligned = ~dataadr[0];
        st_data = {2{writedata[15:0]}};
        st_mask = dataadr[1] ? 4'b1100 : 4'b0011;
      end
      ST_WORD: begin
        aligned = (dataadr[1:0] == 2'b00);
        st_data = writedata;
        st_mask = 4'b1111;
      end
      default: begin
        aligned = 1'b1;
        st_data = '0;
        st_mask = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Store buffer
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] sb_idx  [SB_DEPTH];
  logic [31:0]      sb_data [SB_DEPTH];
  logic [3:0]       sb_mask [SB_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic             full;
  logic             hazard;
  logic             push;
  logic             drain;
  logic             load_ok;
  logic [PTR_W-1:0] age;

  assign full = (count == DEPTH_CNT);

  // An entry is live when its distance from the read pointer (modulo
  // depth) is below the occupancy count.
  always_comb begin
    hazard = 1'b0;
    age    = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      age = PTR_W'(i) - rd_ptr;
      if (({1'b0, age} < count) && (sb_idx[PTR_W'(i)] == req_idx)) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard & memread;
  end

  assign stall   = (store_req && aligned && full) ||
                   (memread && !store_req && hazard);
  assign push    = store_req && aligned && !full;
  // Retirement is suppressed under reset so that discarded stores can
  // never reach the array.
  assign drain   = (count != '0) && (stall || (!store_req && !memread)) &&
                   !reset;
  assign load_ok = memread && !store_req && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (drain) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, drain})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      sb_idx[wr_ptr]  <= req_idx;
      sb_data[wr_ptr] <= st_data;
      sb_mask[wr_ptr] <= st_mask;
    end
  end

  // ---------------------------------------------------------------------
  // Word array (single port: retirement and loads never share a cycle)
  // ---------------------------------------------------------------------
  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (drain) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (sb_mask[rd_ptr][2'(l)]) begin
          mem[sb_idx[rd_ptr]][l*8 +: 8] <= sb_data[rd_ptr][l*8 +: 8];
        end
      end
    end
  end

  assign readdata = load_ok ? mem[req_idx] : '0;

  // ---------------------------------------------------------------------
  // Misaligned-store flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else if (store_req && !aligned) begin
      misalign_err <= 1'b1;
    end
  end

`ifdef DMEM_STORE_TRACE_EN
  logic [31:0] retired_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
    end else begin
      if (drain) begin
        retired_cnt <= retired_cnt + 32'd1;
        $display("STORE %0d adr=%h data=%h mask=%b", retired_cnt + 32'd1,
                 32'({sb_idx[rd_ptr], 2'b00}), sb_data[rd_ptr],
                 sb_mask[rd_ptr]);
      end
      if (store_req && !aligned) begin
        $display("STORE MISALIGNED adr=%h", dataadr);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_dmem_store_responder.sv
// Testbench for dmem_store_responder: directed test-plan sequences plus a
// randomized phase, all checked every cycle against a queue/byte-level
// reference model of the store buffer and memory.

module tb_dmem_store_responder;

  logic        clk;
  logic        reset;
  logic [1:0]  memwrite;
  logic        memread;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        misalign_err;

  dmem_store_responder #(
    .MEM_WORDS (64),
    .SB_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memread      (memread),
    .dataadr      (dataadr),
    .writedata    (writedata),
    .readdata     (readdata),
    .stall        (stall),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned idx;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;

  logic [31:0] m_mem [64];
  ent_t        m_q [$];
  logic        m_err;

  logic        last_e_stall;
  logic        obs_stall;
  logic [31:0] obs_rd;
  logic        obs_err;

  function automatic logic m_aligned(input logic [1:0] mw,
                                     input logic [31:0] a);
    case (mw)
      2'd2:    return (a % 2) == 0;
      2'd3:    return (a % 4) == 0;
      default: return 1'b1;
    endcase
  endfunction

  // One clock cycle: drive, check at negedge, advance the model at posedge.
  task automatic step(input logic rst, input logic [1:0] mw,
                      input logic mr, input logic [31:0] a,
                      input logic [31:0] wd);
    int unsigned idx;
    int unsigned size;
    int unsigned base;
    logic        is_st;
    logic        al;
    logic        full;
    logic        hit;
    logic        e_stall;
    logic [31:0] e_rd;
    ent_t        e;
    reset     = rst;
    memwrite  = mw;
    memread   = mr;
    dataadr   = a;
    writedata = wd;
    idx   = (a / 4) % 64;
    is_st = (mw != 2'd0);
    al    = m_aligned(mw, a);
    full  = (m_q.size() == 4);
    hit   = 1'b0;
    foreach (m_q[k]) if (m_q[k].idx == idx) hit = 1'b1;
    e_stall = (is_st && al && full) || (mr && !is_st && hit);
    e_rd    = (mr && !is_st && !e_stall) ? m_mem[idx] : 32'd0;
    @(negedge clk);
    obs_stall = stall;
    obs_rd    = readdata;
    obs_err   = misalign_err;
    check("stall", {31'd0, stall}, {31'd0, e_stall});
    check("readdata", readdata, e_rd);
    check("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
    last_e_stall = e_stall;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_err = 1'b0;
    end else begin
      if (m_q.size() > 0 && (e_stall || (!is_st && !mr))) begin
        e = m_q.pop_front();
        for (int b = 0; b < 4; b++)
          if (e.mask[b]) m_mem[e.idx][b*8 +: 8] = e.data[b*8 +: 8];
      end
      if (is_st && al && !full) begin
        size   = (mw == 2'd1) ? 1 : (mw == 2'd2) ? 2 : 4;
        base   = a % 4;
        e.idx  = idx;
        e.data = '0;
        e.mask = '0;
        for (int unsigned k = 0; k < size; k++) begin
          e.data[(base+k)*8 +: 8] = wd[k*8 +: 8];
          e.mask[base+k]          = 1'b1;
        end
        m_q.push_back(e);
      end
      if (is_st && !al) m_err = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
  endtask

  // Issue a request and keep holding it while the model says stall.
  task automatic issue(input logic [1:0] mw, input logic mr,
                       input logic [31:0] a, input logic [31:0] wd);
    int tries = 0;
    step(1'b0, mw, mr, a, wd);
    while (last_e_stall && tries < 8) begin
      step(1'b0, mw, mr, a, wd);
      tries++;
    end
    if (tries >= 8) check("stall_bound", 32'd1, 32'd0);
  endtask

  initial begin
    logic [31:0] pre;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  mw;
    logic        mr;
    logic        rst;
    int unsigned r;

    reset = 1'b1; memwrite = 2'd0; memread = 1'b0;
    dataadr = '0; writedata = '0;
    m_err = 1'b0; last_e_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 2'd0, 1'b0, 32'd0, 32'd0);
    check("reset_stall", {31'd0, obs_stall}, 32'd0);
    reset = 1'b0;

    // Give every array word a known value.
    for (int unsigned w = 0; w < 64; w++) begin
      d = $urandom;
      if (w >= 25 && w <= 27) d = 32'hA5A5_0000 + w;
      issue(2'd3, 1'b0, w * 4, d);
    end
    idle(5);
    check("reset_err", {31'd0, obs_err}, 32'd0);

    // Basic store/load
    step(1'b0, 2'd3, 1'b0, 32'd84, 32'd7);
    check("basic_sw_stall", {31'd0, obs_stall}, 32'd0);
    idle(1);
    step(1'b0, 2'd0, 1'b1, 32'd84, 32'd0);
    check("basic_lw", obs_rd, 32'h0000_0007);
    check("basic_lw_stall", {31'd0, obs_stall}, 32'd0);

    // Load hitting the buffer
    step(1'b0, 2'd3, 1'b0, 32'd84, 32'd0);
    idle(2);
    step(1'b0, 2'd3, 1'b0, 32'd84, 32'd7);
    step(1'b0, 2'd0, 1'b1, 32'd84, 32'd0);
    check("hit_stall", {31'd0, obs_stall}, 32'd1);
    check("hit_rd_during_stall", obs_rd, 32'd0);
    step(1'b0, 2'd0, 1'b1, 32'd84, 32'd0);
    check("hit_released", {31'd0, obs_stall}, 32'd0);
    check("hit_lw", obs_rd, 32'h0000_0007);

    // Buffer full
    for (int unsigned k = 0; k < 4; k++) begin
      step(1'b0, 2'd3, 1'b0, k * 4, k + 1);
      check("full_accept", {31'd0, obs_stall}, 32'd0);
    end
    step(1'b0, 2'd3, 1'b0, 32'd16, 32'd5);
    check("full_stall", {31'd0, obs_stall}, 32'd1);
    step(1'b0, 2'd3, 1'b0, 32'd16, 32'd5);
    check("full_retry", {31'd0, obs_stall}, 32'd0);
    idle(4);
    for (int unsigned k = 0; k < 5; k++) begin
      step(1'b0, 2'd0, 1'b1, k * 4, 32'd0);
      check("full_lw", obs_rd, k + 1);
    end

    // Sub-word merge
    step(1'b0, 2'd3, 1'b0, 32'd32, 32'd0);
    step(1'b0, 2'd1, 1'b0, 32'd33, 32'h0000_00AB);
    step(1'b0, 2'd2, 1'b0, 32'd34, 32'h0000_1234);
    idle(3);
    step(1'b0, 2'd0, 1'b1, 32'd32, 32'd0);
    check("merge_lw", obs_rd, 32'h1234_AB00);

    // Misaligned half store
    pre = m_mem[10];
    step(1'b0, 2'd2, 1'b0, 32'd41, 32'h0000_FFFF);
    check("mis_stall", {31'd0, obs_stall}, 32'd0);
    check("mis_err_before", {31'd0, obs_err}, 32'd0);
    idle(1);
    check("mis_err_set", {31'd0, obs_err}, 32'd1);
    idle(1);
    step(1'b0, 2'd0, 1'b1, 32'd40, 32'd0);
    check("mis_lw", obs_rd, pre);

    // Reset mid-operation
    pre = m_mem[25];
    step(1'b0, 2'd3, 1'b0, 32'd100, 32'd9);
    step(1'b0, 2'd3, 1'b0, 32'd104, 32'd9);
    step(1'b0, 2'd3, 1'b0, 32'd108, 32'd9);
    step(1'b1, 2'd0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 2'd0, 1'b1, 32'd100, 32'd0);
    check("rst_lw", obs_rd, pre);
    check("rst_not9", {31'd0, obs_rd == 32'd9}, 32'd0);
    check("rst_err", {31'd0, obs_err}, 32'd0);
    check("rst_stall", {31'd0, obs_stall}, 32'd0);

    // Randomized traffic over a narrow address window to provoke hazards.
    mw = 2'd0; mr = 1'b0; a = '0; d = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!last_e_stall) begin
        r  = $urandom_range(0, 99);
        a  = $urandom;
        a[7:2] = 6'($urandom_range(0, 7));
        d  = $urandom;
        mw = 2'd0;
        mr = 1'b0;
        if (r < 35) begin
          mw = 2'($urandom_range(1, 3));
          mr = ($urandom_range(0, 9) == 0);
          if ($urandom_range(0, 9) != 0) begin
            if (mw == 2'd3) a[1:0] = 2'b00;
            if (mw == 2'd2) a[0] = 1'b0;
          end
        end else if (r < 70) begin
          mr = 1'b1;
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      step(rst, mw, mr, a, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
